// File: rtl/pattern_detector_param_pkg.sv
// Shared types and sizing helpers for the programmable serial pattern detector.
package pd_pkg;

    typedef enum logic [1:0] {
        PD_IDLE = 2'd0,
        PD_FILL = 2'd1,
        PD_RUN  = 2'd2
    } pd_state_t;

    localparam int PD_PAT_W_DEFAULT  = 8;
    localparam int PD_FILL_W_DEFAULT = $clog2(PD_PAT_W_DEFAULT + 1);

    // Fill counter must represent 0..pat_w inclusive.
    function automatic int pd_fill_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/pattern_detector_param_if.sv
// Control, configuration, serial data and result signals of the pattern detector.
interface pattern_detector_param_if #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 16
);
    logic             enable;
    logic             overlap_en;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic [PAT_W-1:0] cfg_mask;
    logic             data_valid;
    logic             data_in;
    logic             cnt_clr;
    logic             detected;
    logic             armed;
    logic [CNT_W-1:0] match_count;

    modport master (
        output enable, overlap_en, cfg_load, cfg_pattern, cfg_mask,
        output data_valid, data_in, cnt_clr,
        input  detected, armed, match_count
    );

    modport slave (
        input  enable, overlap_en, cfg_load, cfg_pattern, cfg_mask,
        input  data_valid, data_in, cnt_clr,
        output detected, armed, match_count
    );
endinterface

// File: rtl/pattern_detector_param_match_counter.sv
// Saturating match counter; clear wins over a simultaneous increment.
module pd_match_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    // Count register: clear, saturating increment, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= {CNT_W{1'b0}};
        end else if (clr) begin
            count <= {CNT_W{1'b0}};
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1'b1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/pattern_detector_param.sv
// Programmable masked serial pattern detector with overlap/non-overlap modes.
// Define PD_MATCH_CNT_EN to build the saturating match counter and cnt_clr.
module pattern_detector_param
    import pd_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pattern_detector_param_if.slave bus
);

    localparam int                FILL_W    = pd_fill_width(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    pd_state_t         state_r;
    pd_state_t         state_s;
    logic [PAT_W-1:0]  hist_r;
    logic [PAT_W-1:0]  hist_s;
    logic [PAT_W-1:0]  hist_shift_s;
    logic [PAT_W-1:0]  pattern_r;
    logic [PAT_W-1:0]  mask_r;
    logic [FILL_W-1:0] fill_r;
    logic [FILL_W-1:0] fill_s;
    logic [FILL_W-1:0] fill_inc_s;
    logic              accept_s;
    logic              match_s;
    logic              detected_r;
    logic              armed_r;

    // Candidate window after accepting the current bit, and its compare result.
    always_comb begin
        hist_shift_s = {hist_r[PAT_W-2:0], bus.data_in};
        if (fill_r == FILL_FULL) begin
            fill_inc_s = fill_r;
        end else begin
            fill_inc_s = fill_r + FILL_W'(1'b1);
        end
        accept_s = bus.enable & bus.data_valid & ~bus.cfg_load;
        match_s  = accept_s && (fill_inc_s == FILL_FULL) &&
                   (((hist_shift_s ^ pattern_r) & mask_r) == {PAT_W{1'b0}});
    end

    // Next-state logic: disable and reload both flush the window.
    always_comb begin
        state_s = state_r;
        hist_s  = hist_r;
        fill_s  = fill_r;
        if (!bus.enable) begin
            state_s = PD_IDLE;
            hist_s  = {PAT_W{1'b0}};
            fill_s  = {FILL_W{1'b0}};
        end else if (bus.cfg_load) begin
            state_s = PD_FILL;
            hist_s  = {PAT_W{1'b0}};
            fill_s  = {FILL_W{1'b0}};
        end else begin
            case (state_r)
                PD_IDLE: state_s = PD_FILL;
                PD_FILL: state_s = PD_FILL;
                PD_RUN:  state_s = PD_RUN;
                default: begin
                    state_s = PD_FILL;
                    hist_s  = {PAT_W{1'b0}};
                    fill_s  = {FILL_W{1'b0}};
                end
            endcase
            if (accept_s) begin
                hist_s = hist_shift_s;
                fill_s = fill_inc_s;
                if (match_s && !bus.overlap_en) begin
                    state_s = PD_FILL;
                    hist_s  = {PAT_W{1'b0}};
                    fill_s  = {FILL_W{1'b0}};
                end else if (fill_inc_s == FILL_FULL) begin
                    state_s = PD_RUN;
                end else begin
                    state_s = PD_FILL;
                end
            end else begin
                hist_s = hist_s;
            end
        end
    end

    // FSM, window and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= PD_IDLE;
            hist_r     <= {PAT_W{1'b0}};
            fill_r     <= {FILL_W{1'b0}};
            detected_r <= 1'b0;
            armed_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            hist_r     <= hist_s;
            fill_r     <= fill_s;
            detected_r <= match_s;
            armed_r    <= (state_s == PD_RUN);
        end
    end

    // Pattern/mask capture happens even while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_r <= {PAT_W{1'b0}};
            mask_r    <= {PAT_W{1'b1}};
        end else if (bus.cfg_load) begin
            pattern_r <= bus.cfg_pattern;
            mask_r    <= bus.cfg_mask;
        end else begin
            pattern_r <= pattern_r;
            mask_r    <= mask_r;
        end
    end

    assign bus.detected = detected_r;
    assign bus.armed    = armed_r;

`ifdef PD_MATCH_CNT_EN
    logic [CNT_W-1:0] count_s;

    pd_match_counter #(.CNT_W(CNT_W)) u_match_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (match_s),
        .clr   (bus.cnt_clr),
        .count (count_s)
    );

    assign bus.match_count = count_s;
`else
    logic unused_cnt_clr_s;
    assign unused_cnt_clr_s = bus.cnt_clr;
    assign bus.match_count  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pattern_detector_param.sv
// Self-checking bench: directed scenarios plus random traffic against a bit-queue reference model.
module tb_pattern_detector_param;

    localparam int PW = 8;
    localparam int CW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pattern_detector_param_if #(.PAT_W(PW), .CNT_W(CW)) bus ();

    pattern_detector_param #(.PAT_W(PW), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
`ifdef PD_MATCH_CNT_EN
    int cnt_on = 1;
`else
    int cnt_on = 0;
`endif

    // Reference model: the accepted bits since the last window restart, oldest first.
    bit             q[$];
    logic [PW-1:0]  m_pat;
    logic [PW-1:0]  m_mask;
    int             m_cnt;
    logic           exp_det;
    logic           exp_armed;
    logic [CW-1:0]  exp_cnt;

    function automatic bit window_ok();
        logic [PW-1:0] w = '0;
        foreach (q[i]) w = {w[PW-2:0], q[i]};
        return ((w ^ m_pat) & m_mask) == '0;
    endfunction

    task automatic model_reset();
        q.delete();
        m_pat = '0; m_mask = '1; m_cnt = 0;
        exp_det = 1'b0; exp_armed = 1'b0; exp_cnt = '0;
    endtask

    // Drive one clock's inputs, advance the model, sample 1 time unit after the edge.
    task automatic step(input logic en, input logic ov, input logic ld,
                        input logic [PW-1:0] pat, input logic [PW-1:0] msk,
                        input logic dv, input logic di, input logic clr);
        bus.enable = en; bus.overlap_en = ov; bus.cfg_load = ld;
        bus.cfg_pattern = pat; bus.cfg_mask = msk;
        bus.data_valid = dv; bus.data_in = di; bus.cnt_clr = clr;
        exp_det = 1'b0;
        if (ld) begin m_pat = pat; m_mask = msk; end
        if (!en || ld) q.delete();
        else if (dv) begin
            q.push_back(di);
            if (q.size() > PW) void'(q.pop_front());
            if (q.size() == PW && window_ok()) begin
                exp_det = 1'b1;
                if (!ov) q.delete();
            end
        end
        exp_armed = en && !ld && (q.size() == PW);
        if (cnt_on == 0) m_cnt = 0;
        else if (clr) m_cnt = 0;
        else if (exp_det && m_cnt < (1 << CW) - 1) m_cnt++;
        exp_cnt = CW'(m_cnt);
        @(posedge clk);
        #1;
    endtask

    // Shift n bits (MSB first); record observed and modelled pulse positions (bit 31 = pulse in a bubble).
    task automatic send_bits(input logic [31:0] bits, input int n, input logic ov, input bit gap,
                             output int obs, output int mdl, output int arm_bad);
        obs = 0; mdl = 0; arm_bad = 0;
        for (int i = 0; i < n; i++) begin
            step(1'b1, ov, 1'b0, '0, '0, 1'b1, bits[n-1-i], 1'b0);
            if (bus.detected === 1'b1) obs |= (1 << (i + 1));
            if (exp_det) mdl |= (1 << (i + 1));
            if (bus.armed !== exp_armed) arm_bad++;
            if (gap) begin
                step(1'b1, ov, 1'b0, '0, '0, 1'b0, 1'($urandom), 1'b0);
                if (bus.detected === 1'b1) obs |= 32'h8000_0000;
                if (exp_det) mdl |= 32'h8000_0000;
                if (bus.armed !== exp_armed) arm_bad++;
            end
        end
    endtask

    task automatic test_reset();
        bus.enable = 1'b0; bus.overlap_en = 1'b0; bus.cfg_load = 1'b0;
        bus.cfg_pattern = '0; bus.cfg_mask = '0; bus.data_valid = 1'b0;
        bus.data_in = 1'b0; bus.cnt_clr = 1'b0;
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.detected, bus.armed, bus.match_count} !== {2'b00, {CW{1'b0}}}) begin
            errors++;
            $display("FAIL reset_idle: det=%b armed=%b cnt=%0d, want 0 0 0", bus.detected, bus.armed, bus.match_count);
        end
        rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b0, '0, '0, 1'b1, 1'($urandom), 1'b0);
        checks++;
        if ({bus.detected, bus.armed} !== 2'b11 || bus.match_count !== exp_cnt) begin
            errors++;
            $display("FAIL reset_prerun: det=%b armed=%b cnt=%0d, want 1 1 %0d", bus.detected, bus.armed, bus.match_count, exp_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({bus.detected, bus.armed, bus.match_count} !== {2'b00, {CW{1'b0}}}) begin
            errors++;
            $display("FAIL reset_async: det=%b armed=%b cnt=%0d, want 0 0 0", bus.detected, bus.armed, bus.match_count);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        // After reset the pattern is 0 with a full mask, so eight zeros complete a match.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (bus.detected !== 1'(i == 8) || bus.armed !== 1'(i == 8)) begin
                errors++;
                $display("FAIL reset_refill bit %0d: det=%b armed=%b, want %b %b", i, bus.detected, bus.armed, i == 8, i == 8);
            end
        end
    endtask

    task automatic test_b5_nonoverlap();
        int obs, mdl, ab;
        step(1'b1, 1'b0, 1'b1, 8'hB5, 8'hFF, 1'b0, 1'b0, 1'b1);
        send_bits(32'h0000_B5B5, 16, 1'b0, 1'b0, obs, mdl, ab);
        checks++;
        if (obs !== ((1 << 8) | (1 << 16)) || mdl !== obs || ab != 0) begin
            errors++;
            $display("FAIL b5_pulses: got %h model %h armed_err %0d, want %h", obs, mdl, ab, (1 << 8) | (1 << 16));
        end
        checks++;
        if (bus.match_count !== CW'(2 * cnt_on)) begin
            errors++;
            $display("FAIL b5_count: got %0d, want %0d", bus.match_count, 2 * cnt_on);
        end
    endtask

    task automatic test_aa_overlap_modes();
        int obs, mdl, ab;
        step(1'b1, 1'b1, 1'b1, 8'hAA, 8'hFF, 1'b0, 1'b0, 1'b0);
        send_bits(32'h0000_02AA, 10, 1'b1, 1'b0, obs, mdl, ab);
        checks++;
        if (obs !== ((1 << 8) | (1 << 10)) || mdl !== obs || ab != 0) begin
            errors++;
            $display("FAIL aa_overlap: got %h model %h armed_err %0d, want %h", obs, mdl, ab, (1 << 8) | (1 << 10));
        end
        step(1'b1, 1'b0, 1'b1, 8'hAA, 8'hFF, 1'b0, 1'b0, 1'b0);
        send_bits(32'h0000_02AA, 10, 1'b0, 1'b0, obs, mdl, ab);
        checks++;
        if (obs !== (1 << 8) || mdl !== obs || ab != 0) begin
            errors++;
            $display("FAIL aa_nonoverlap: got %h model %h armed_err %0d, want %h", obs, mdl, ab, 1 << 8);
        end
    endtask

    task automatic test_mask();
        int obs, mdl, ab;
        step(1'b1, 1'b0, 1'b1, 8'hA0, 8'hF0, 1'b0, 1'b0, 1'b0);
        send_bits(32'h0000_00A7, 8, 1'b0, 1'b0, obs, mdl, ab);
        checks++;
        if (obs !== (1 << 8) || mdl !== obs) begin
            errors++;
            $display("FAIL mask_a7: got %h model %h, want %h", obs, mdl, 1 << 8);
        end
        send_bits(32'h0000_00B7, 8, 1'b0, 1'b0, obs, mdl, ab);
        checks++;
        if (obs !== 0 || mdl !== obs || bus.armed !== 1'b1) begin
            errors++;
            $display("FAIL mask_b7: got %h model %h armed %b, want 0 armed 1", obs, mdl, bus.armed);
        end
    endtask

    task automatic test_bubbles_reload();
        int obs, mdl, ab;
        step(1'b1, 1'b0, 1'b1, 8'hB5, 8'hFF, 1'b0, 1'b0, 1'b0);
        send_bits(32'h0000_00B5, 8, 1'b0, 1'b1, obs, mdl, ab);
        checks++;
        if (obs !== (1 << 8) || mdl !== obs || ab != 0) begin
            errors++;
            $display("FAIL bubble_match: got %h model %h armed_err %0d, want %h", obs, mdl, ab, 1 << 8);
        end
        send_bits(32'h0000_0016, 5, 1'b0, 1'b0, obs, mdl, ab);
        step(1'b1, 1'b0, 1'b1, 8'hB5, 8'hFF, 1'b1, 1'b1, 1'b0);
        checks++;
        if (bus.detected !== 1'b0 || bus.armed !== 1'b0) begin
            errors++;
            $display("FAIL reload_strobe: det=%b armed=%b, want 0 0", bus.detected, bus.armed);
        end
        send_bits(32'h0000_00B5, 8, 1'b0, 1'b0, obs, mdl, ab);
        checks++;
        if (obs !== (1 << 8) || mdl !== obs || ab != 0) begin
            errors++;
            $display("FAIL reload_refill: got %h model %h armed_err %0d, want %h", obs, mdl, ab, 1 << 8);
        end
    endtask

    task automatic test_saturation();
        int obs, mdl, ab;
        step(1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        send_bits(32'h0000_0000, 27, 1'b1, 1'b0, obs, mdl, ab);
        checks++;
        if (bus.match_count !== CW'(15 * cnt_on) || mdl !== obs) begin
            errors++;
            $display("FAIL sat_count: got %0d, want %0d (pulses %h model %h)", bus.match_count, 15 * cnt_on, obs, mdl);
        end
        step(1'b1, 1'b1, 1'b0, '0, '0, 1'b1, 1'b1, 1'b1);
        checks++;
        if (bus.match_count !== {CW{1'b0}} || bus.detected !== 1'b1) begin
            errors++;
            $display("FAIL clr_on_match: cnt=%0d det=%b, want 0 1", bus.match_count, bus.detected);
        end
        step(1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (bus.armed !== 1'b0 || bus.detected !== 1'b0) begin
            errors++;
            $display("FAIL disable_drop: armed=%b det=%b, want 0 0", bus.armed, bus.detected);
        end
    endtask

    task automatic test_random();
        int shown = 0;
        for (int n = 0; n < 3000; n++) begin
            step(1'($urandom_range(0, 19) != 0), 1'($urandom), 1'($urandom_range(0, 59) == 0),
                 PW'($urandom), PW'($urandom & $urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom), 1'($urandom_range(0, 79) == 0));
            checks++;
            if ({bus.detected, bus.armed, bus.match_count} !== {exp_det, exp_armed, exp_cnt}) begin
                errors++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random cycle %0d: det=%b armed=%b cnt=%0d, want %b %b %0d",
                             n, bus.detected, bus.armed, bus.match_count, exp_det, exp_armed, exp_cnt);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_b5_nonoverlap();
        test_aa_overlap_modes();
        test_mask();
        test_bubbles_reload();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
